// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes, datapath width, and the in-flight tag.
// The tag records whether an operation is in flight and which requester it belongs to.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_EQ  = 3'b110;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

endpackage

// File: rtl/alu_tag_pipe.sv
// Shifts a {vld,id} tag alongside the ALU pipeline, so each tag leaves ALU_LAT cycles after it enters.
// It never stalls, and reset clears every stage so that in-flight operations are dropped.
module alu_tag_pipe
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_busy
);

    tag_t [ALU_LAT-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < ALU_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[ALU_LAT-1];

    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < ALU_LAT; i++) begin
            o_busy = o_busy | r_stage[i].vld;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin front end for a shared pipelined ALU; it issues one operation per cycle.
// A response appears ALU_LAT+1 cycles after issue, and responses have no backpressure.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int W       = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_sel,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_sel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_result,
    input  logic         alu_carry,
    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_data,
    output logic         rsp0_carry,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_data,
    output logic         rsp1_carry,
    output logic         busy
);

    logic         r_last_gnt;
    logic         w_gnt_vld;
    logic         w_gnt_id;
    tag_t         w_tag_in;
    tag_t         w_tag_out;
    logic         w_pipe_busy;
    logic         r_rsp0_valid;
    logic [W-1:0] r_rsp0_data;
    logic         r_rsp0_carry;
    logic         r_rsp1_valid;
    logic [W-1:0] r_rsp1_data;
    logic         r_rsp1_carry;

    // Under contention, the requester that did not win last time is granted.
    always_comb begin
        w_gnt_vld = !rst && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last_gnt;
        end else begin
            w_gnt_id = req1_valid;
        end
    end

    assign req0_ready = w_gnt_vld && !w_gnt_id;
    assign req1_ready = w_gnt_vld &&  w_gnt_id;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = OP_ADD;
        if (req0_ready) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_sel = req0_sel;
        end else if (req1_ready) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_sel = req1_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt_vld) begin
            r_last_gnt <= w_gnt_id;
        end
    end

    assign w_tag_in = {w_gnt_vld, w_gnt_id};

    alu_tag_pipe #(
        .ALU_LAT (ALU_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_tag  (w_tag_in),
        .o_tag  (w_tag_out),
        .o_busy (w_pipe_busy)
    );

    // The data registers load only for their own requester, so each port holds its last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp0_carry <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
            r_rsp1_carry <= 1'b0;
        end else begin
            r_rsp0_valid <= w_tag_out.vld && !w_tag_out.id;
            r_rsp1_valid <= w_tag_out.vld &&  w_tag_out.id;
            if (w_tag_out.vld && !w_tag_out.id) begin
                r_rsp0_data  <= alu_result;
                r_rsp0_carry <= alu_carry;
            end
            if (w_tag_out.vld && w_tag_out.id) begin
                r_rsp1_data  <= alu_result;
                r_rsp1_carry <= alu_carry;
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp0_carry = r_rsp0_carry;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_data  = r_rsp1_data;
    assign rsp1_carry = r_rsp1_carry;
    assign busy       = w_pipe_busy | r_rsp0_valid | r_rsp1_valid;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a behavioural ALU with ALU_LAT register stages, and a queue-based reference
// model of the grant order, response timing and hold values.
module tb_alu_rr_arbiter;

    localparam int ALU_LAT = 2;
    localparam int W       = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_sel, req1_sel;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_sel;
    logic         alu_carry;
    logic         rsp0_valid, rsp0_carry, rsp1_valid, rsp1_carry, busy;
    logic [W-1:0] rsp0_data, rsp1_data;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.ALU_LAT(ALU_LAT), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_carry(rsp0_carry),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_carry(rsp1_carry),
        .busy(busy)
    );

    // Returns {carry, result}.
    function automatic logic [4:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return (a > b) ? 5'd1 : 5'd0;
            3'd6:    return (a == b) ? 5'd1 : 5'd0;
            default: return 5'd0;
        endcase
    endfunction

    logic [4:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_sel, alu_a, alu_b);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[ALU_LAT-1][3:0];
    assign alu_carry  = alu_pipe[ALU_LAT-1][4];

    typedef struct {
        int         due;
        bit         id;
        logic [4:0] res;
    } exp_t;

    exp_t       q[$];
    int         errs = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         last_gnt = 1'b1;
    logic [4:0] hold [2];
    bit         p_v [2];
    logic [3:0] p_a [2];
    logic [3:0] p_b [2];
    logic [2:0] p_s [2];
    bit         got [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        bit   g, gid, e0, e1;
        exp_t e;
        req0_valid = p_v[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_sel = p_s[0];
        req1_valid = p_v[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_sel = p_s[1];
        #1;
        g = 1'b0; gid = 1'b0;
        if (rst) begin
            q.delete();
            hold[0] = '0; hold[1] = '0;
            last_gnt = 1'b1;
        end else if (p_v[0] && p_v[1]) begin
            g = 1'b1;
            gid = (last_gnt == 1'b1) ? 1'b0 : 1'b1;
        end else if (p_v[0] || p_v[1]) begin
            g = 1'b1;
            gid = p_v[1];
        end
        chk("busy", busy, (q.size() > 0) ? 8'd1 : 8'd0);
        e0 = 1'b0; e1 = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            hold[e.id] = e.res;
            if (e.id) e1 = 1'b1; else e0 = 1'b1;
        end
        chk("req0_ready", req0_ready, (g && !gid) ? 8'd1 : 8'd0);
        chk("req1_ready", req1_ready, (g && gid) ? 8'd1 : 8'd0);
        chk("alu_a", alu_a, g ? p_a[gid] : 4'd0);
        chk("alu_b", alu_b, g ? p_b[gid] : 4'd0);
        chk("alu_sel", alu_sel, g ? p_s[gid] : 3'd0);
        chk("rsp0_valid", rsp0_valid, e0);
        chk("rsp1_valid", rsp1_valid, e1);
        chk("rsp0_data", rsp0_data, hold[0][3:0]);
        chk("rsp0_carry", rsp0_carry, hold[0][4]);
        chk("rsp1_data", rsp1_data, hold[1][3:0]);
        chk("rsp1_carry", rsp1_carry, hold[1][4]);
        got[0] = 1'b0; got[1] = 1'b0;
        if (g) begin
            q.push_back('{due: cyc + ALU_LAT + 1, id: gid, res: alu_f(p_s[gid], p_a[gid], p_b[gid])});
            last_gnt = gid;
            got[gid] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_op(input int n, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        p_v[n] = 1'b1; p_s[n] = s; p_a[n] = a; p_b[n] = b;
    endtask

    task automatic drain(input int n);
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        hold[0] = '0; hold[1] = '0;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin p_a[n] = '0; p_b[n] = '0; p_s[n] = '0; end
        tick();
        // Both requesters are valid while reset is held, so no grant may occur.
        set_op(0, 3'd0, 4'h5, 4'h3);
        set_op(1, 3'd2, 4'hC, 4'hA);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6 && (p_v[0] || p_v[1]); i++) begin
            tick();
            if (got[0]) p_v[0] = 1'b0;
            if (got[1]) p_v[1] = 1'b0;
        end
        chk("both_granted", {p_v[0], p_v[1]}, 8'd0);
        drain(ALU_LAT + 3);

        set_op(0, 3'd0, 4'h5, 4'h3);
        tick();
        drain(ALU_LAT + 3);
        chk("add_5_3", rsp0_data, 8'h8);

        set_op(0, 3'd1, 4'h6, 4'h2);
        set_op(1, 3'd2, 4'hC, 4'hA);
        for (int i = 0; i < 4; i++) tick();
        drain(ALU_LAT + 3);

        set_op(1, 3'd4, 4'hF, 4'hA); tick();
        set_op(1, 3'd5, 4'hA, 4'h5); tick();
        set_op(1, 3'd6, 4'h6, 4'h6); tick();
        drain(ALU_LAT + 3);

        set_op(0, 3'd0, 4'hF, 4'h1);
        tick();
        drain(ALU_LAT + 3);
        chk("carry_out", {rsp0_carry, rsp0_data}, 8'h10);

        // Reset arrives while two operations are in flight.
        set_op(0, 3'd0, 4'h1, 4'h2); tick();
        set_op(1, 3'd0, 4'h3, 4'h4); p_v[0] = 1'b0; tick();
        p_v[1] = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drain(ALU_LAT + 2);
        set_op(0, 3'd0, 4'h7, 4'h7);
        tick();
        drain(ALU_LAT + 3);

        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!p_v[n] && $urandom_range(0, 1) == 1)
                    set_op(n, 3'($urandom_range(0, 6)), 4'($urandom), 4'($urandom));
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
            if (got[0]) p_v[0] = 1'b0;
            if (got[1]) p_v[1] = 1'b0;
        end
        rst = 1'b0;
        drain(ALU_LAT + 3);
        chk("queue_empty", 8'(q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
